// File: rtl/fp_mul_fsm.sv
// Multi-cycle floating-point multiplier/squarer: IDLE -> MUL -> NORM -> ROUND -> PACK.
// Denormal operands are treated as zero, and underflowing results are flushed to zero.
module fp_mul_fsm #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1+EXP_W+MANT_W-1:0]     x,
    input  logic [1+EXP_W+MANT_W-1:0]     y,
    input  logic                          mode,
    input  logic                          r_i,
    output logic [1+EXP_W+MANT_W-1:0]     res,
    output logic                          err,
    output logic                          uflow,
    output logic                          busy,
    output logic                          r_o
);

    localparam int unsigned W    = 1 + EXP_W + MANT_W;
    localparam int unsigned SIGW = MANT_W + 1;
    localparam int unsigned P    = 2 * SIGW;
    localparam int unsigned EW2  = EXP_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
        ROUND,
        PACK
    } state_t;

    state_t state_q, state_nx;

    logic [SIGW-1:0]   man_a, man_b;
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic              sign_q, nan_q, zero_q;
    logic [P-1:0]      prod_q;
    logic [SIGW-1:0]   mant_q;
    logic              guard_q, sticky_q;
    logic [EW2-1:0]    exp_q;

    logic [W-1:0]      y_eff;
    logic [P-1:0]      norm;
    logic [EW2-1:0]    exp_sum;
    logic              rnd_up;
    logic [SIGW:0]     rnd_sum;
    logic [SIGW-1:0]   rnd_mant;
    logic [EW2-1:0]    rnd_exp;
    logic [W-1:0]      pack_res;
    logic              pack_err, pack_uflow;

    // State register; busy mirrors the next state so it is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            state_q <= state_nx;
            busy    <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (r_i) state_nx = MUL;
            MUL:     state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = PACK;
            PACK:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath combinational helpers for each stage
    always_comb begin
        y_eff      = mode ? y : x;
        norm       = prod_q[P-1] ? prod_q : P'(prod_q << 1);
        exp_sum    = EW2'(exp_a) + EW2'(exp_b) - EW2'(BIAS) + EW2'(prod_q[P-1]);
        rnd_up     = guard_q & (sticky_q | mant_q[0]);
        rnd_sum    = (SIGW + 1)'(mant_q) + (SIGW + 1)'(rnd_up);
        rnd_mant   = rnd_sum[SIGW] ? rnd_sum[SIGW:1] : rnd_sum[SIGW-1:0];
        rnd_exp    = exp_q + EW2'(rnd_sum[SIGW]);
        pack_res   = '0;
        pack_err   = 1'b0;
        pack_uflow = 1'b0;
        if (nan_q) begin
            pack_res = {1'b0, {EXP_W{1'b1}}, 1'b1, (MANT_W - 1)'(0)};
            pack_err = 1'b1;
        end else if (zero_q) begin
            pack_res = {sign_q, (W - 1)'(0)};
        end else if ($signed(exp_q) >= $signed(EXP_MAX)) begin
            pack_res = {sign_q, {EXP_W{1'b1}}, MANT_W'(0)};
            pack_err = 1'b1;
        end else if ($signed(exp_q) <= $signed(EW2'(0))) begin
            pack_res   = {sign_q, (W - 1)'(0)};
            pack_uflow = 1'b1;
        end else begin
            pack_res = {sign_q, exp_q[EXP_W-1:0], mant_q[MANT_W-1:0]};
        end
    end

    // Stage registers and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            man_a    <= '0;
            man_b    <= '0;
            exp_a    <= '0;
            exp_b    <= '0;
            sign_q   <= 1'b0;
            nan_q    <= 1'b0;
            zero_q   <= 1'b0;
            prod_q   <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            exp_q    <= '0;
            res      <= '0;
            err      <= 1'b0;
            uflow    <= 1'b0;
            r_o      <= 1'b0;
        end else begin
            r_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (r_i) begin
                        man_a  <= {1'b1, x[MANT_W-1:0]};
                        man_b  <= {1'b1, y_eff[MANT_W-1:0]};
                        exp_a  <= x[W-2:MANT_W];
                        exp_b  <= y_eff[W-2:MANT_W];
                        sign_q <= x[W-1] ^ y_eff[W-1];
                        nan_q  <= (&x[W-2:MANT_W]) | (&y_eff[W-2:MANT_W]);
                        zero_q <= (~|x[W-2:MANT_W]) | (~|y_eff[W-2:MANT_W]);
                    end
                end
                MUL: prod_q <= P'(man_a) * P'(man_b);
                NORM: begin
                    mant_q   <= norm[P-1 -: SIGW];
                    guard_q  <= norm[P-1-SIGW];
                    sticky_q <= |norm[P-2-SIGW:0];
                    exp_q    <= exp_sum;
                end
                ROUND: begin
                    mant_q <= rnd_mant;
                    exp_q  <= rnd_exp;
                end
                PACK: begin
                    res   <= pack_res;
                    err   <= pack_err;
                    uflow <= pack_uflow;
                    r_o   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_fsm.sv
// Randomized scoreboard bench for fp_mul_fsm against an integer-arithmetic reference model.
module tb_fp_mul_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] x = '0, y = '0;
    logic        mode = 1'b0, r_i = 1'b0;
    logic [31:0] res;
    logic        err, uflow, busy, r_o;

    fp_mul_fsm dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .mode(mode), .r_i(r_i),
        .res(res), .err(err), .uflow(uflow), .busy(busy), .r_o(r_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic        uflow;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          cnt      = 0;
    logic [31:0] hold_res = '0;
    logic        hold_err = 1'b0, hold_uflow = 1'b0;
    logic        use_dir = 1'b0;
    logic [33:0] dir_val = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
    endtask

    // Reference: exact integer product, then round-to-nearest-even by remainder comparison
    function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, e, sh;
        logic        s;
        longint      p, q, rem, half;
        logic [31:0] r;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if (ea == 255 || eb == 255) return {1'b1, 1'b0, 32'h7FC00000};
        if (ea == 0 || eb == 0) return {1'b0, 1'b0, s, 31'h0};
        p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        sh = (p >= (64'sd1 <<< 47)) ? 24 : 23;
        e  = ea + eb - 127 + (sh - 23);
        q    = p >>> sh;
        rem  = p - (q <<< sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == (64'sd1 <<< 24)) begin
            q = q >>> 1;
            e = e + 1;
        end
        if (e >= 255) return {1'b1, 1'b0, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, 1'b1, s, 31'h0};
        r = {s, 8'(e), 23'(q)};
        return {1'b0, 1'b0, r};
    endfunction

    // Predictor: one capture whenever the block is idle and r_i is seen, then 4 busy cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt = 0;
            sb.delete();
            hold_res = '0;
            hold_err = 1'b0;
            hold_uflow = 1'b0;
        end else begin
            exp_t        e;
            logic [33:0] v;
            cyc++;
            if (cnt == 0 && r_i) begin
                v = use_dir ? dir_val : ref_mul(x, mode ? y : x);
                e.err = v[33];
                e.uflow = v[32];
                e.res = v[31:0];
                e.due = cyc + 4;
                sb.push_back(e);
                cnt = 4;
            end else if (cnt > 0) begin
                cnt--;
            end
        end
    end

    // Monitor: compares outputs on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {r_o, busy, err, uflow, res}, 36'h0);
        end else begin
            chk("busy", busy, (cnt != 0));
            if (r_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_r_o", r_o, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    chk("res", res, e.res);
                    chk("err_uflow", {err, uflow}, {e.err, e.uflow});
                    hold_res = e.res;
                    hold_err = e.err;
                    hold_uflow = e.uflow;
                end
            end else begin
                if (sb.size() > 0 && sb[0].due <= cyc) chk("missing_r_o", r_o, 1'b1);
                chk("held_outputs", {err, uflow, res}, {hold_err, hold_uflow, hold_res});
            end
        end
    end

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex;
        int         k;
        k = $urandom_range(0, 19);
        if (k == 0) ex = 8'h00;
        else if (k == 1) ex = 8'hFF;
        else if (k < 5) ex = 8'($urandom_range(1, 254));
        else ex = 8'($urandom_range(90, 165));
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    // Waits (bounded) for idle, then issues one request
    task automatic do_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                         input logic dir, input logic [33:0] dv);
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) chk("idle_timeout", busy, 1'b0);
        mode = m;
        x = a;
        y = b;
        use_dir = dir;
        dir_val = dv;
        r_i = 1'b1;
        @(posedge clk);
        #1;
        r_i = 1'b0;
        use_dir = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_res", res, 32'h0);
        chk("reset_flags", {err, uflow, busy, r_o}, 4'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(1'b0, 32'h40400000, 32'h0, 1'b1, {2'b00, 32'h41100000});
        do_op(1'b1, 32'hC0000000, 32'h40400000, 1'b1, {2'b00, 32'hC0C00000});
        do_op(1'b1, 32'h3FC00000, 32'h40000000, 1'b1, {2'b00, 32'h40400000});
        do_op(1'b0, 32'h3F800001, 32'h0, 1'b1, {2'b00, 32'h3F800002});
        do_op(1'b0, 32'h7F000000, 32'h0, 1'b1, {2'b10, 32'h7F800000});
        do_op(1'b1, 32'h80000000, 32'h40A00000, 1'b1, {2'b00, 32'h80000000});
        do_op(1'b0, 32'h00800000, 32'h0, 1'b1, {2'b01, 32'h00000000});
        do_op(1'b0, 32'h7FC00000, 32'h0, 1'b1, {2'b10, 32'h7FC00000});
        do_op(1'b0, 32'hBFC00000, 32'h0, 1'b1, {2'b00, 32'h40100000});

        // Abort an operation in NORM
        do_op(1'b0, 32'h40A00000, 32'h0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {res, err, uflow, r_o, busy}, 36'h0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(1'b0, 32'h40400000, 32'h0, 1'b1, {2'b00, 32'h41100000});

        repeat (300) do_op(1'($urandom), rand_fp(), rand_fp(), 1'b0, '0);

        // r_i held high, then random pulses; extra requests while busy must be dropped
        repeat (80) begin
            x = rand_fp();
            y = rand_fp();
            mode = 1'($urandom);
            r_i = 1'b1;
            @(posedge clk);
            #1;
        end
        repeat (150) begin
            x = rand_fp();
            y = rand_fp();
            mode = 1'($urandom);
            r_i = 1'($urandom);
            @(posedge clk);
            #1;
        end
        r_i = 1'b0;

        for (int i = 0; i < 30 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
